gate_truth_table_reader: RTL and testbench

Sequential characterisation block that reads back the Boolean function of a 4-input, 1-output combinational gate netlist. It sweeps all 16 input vectors into the gate, waits a programmable settle time, samples the gate output, and assembles the 16-bit truth-table word used to name designs (for example `16'hE605`). It also compares the word against an expected table. It sits on the bench/characterisation side of each synthesised gate.

---
 rtl/gate_char_pkg.sv | 20 ++
 rtl/settle_timer.sv | 38 +++
 rtl/gate_truth_table_reader.sv | 126 ++++++++++++
 tb/tb_gate_truth_table_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_char_pkg.sv
// Shared types and sizes for the gate truth-table characterisation block.
package gate_char_pkg;

  localparam int N_GATE_IN = 4;
  localparam int N_ROWS    = 16;

  typedef logic [N_ROWS-1:0] tt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } char_state_e;

  // Row 0 lands in the MSB of the truth-table word.
  function automatic logic [N_GATE_IN-1:0] row_bit(input logic [N_GATE_IN-1:0] row);
    return 4'd15 - row;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter: counts while enabled, pulses o_term on count SETTLE_CYCLES-1
// and wraps back to zero on that same edge.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_term
);

  localparam logic [7:0] TERM = 8'(SETTLE_CYCLES - 1);

  logic [7:0] r_count;
  logic       w_at_term;

  assign w_at_term = (r_count == TERM);
  assign o_term    = i_en && w_at_term;

  // Count register; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_en) begin
      if (w_at_term) begin
        r_count <= 8'd0;
      end else begin
        r_count <= r_count + 8'd1;
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/gate_truth_table_reader.sv
// Sweeps all 16 input rows into a 4-input gate, samples its output after a settle
// time and builds the 16-bit truth-table word, comparing it against an expected table.
module gate_truth_table_reader
  import gate_char_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp_table,
  output logic [3:0]  gate_in,
  input  logic        gate_out,
  output logic        busy,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [15:0] truth_table,
  output logic        match,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_bad_row
);

  char_state_e r_state;
  logic [3:0]  r_gate_in;
  tt_t         r_truth_table;
  tt_t         r_exp_table;
  logic [4:0]  r_mismatch_cnt;
  logic [3:0]  r_first_bad_row;

  logic        w_accept_start;
  logic        w_abort;
  logic        w_run;
  logic        w_sample;
  logic [3:0]  w_bit_idx;
  logic        w_bit_bad;

  assign w_run          = (r_state == RUN);
  assign w_accept_start = (r_state == IDLE) && start;
  assign w_abort        = w_run && abort;
  assign w_bit_idx      = row_bit(r_gate_in);
  assign w_bit_bad      = (gate_out != r_exp_table[w_bit_idx]);

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_accept_start || w_abort),
    .i_en   (w_run),
    .o_term (w_sample)
  );

  // FSM, row counter, capture and mismatch bookkeeping; abort beats a same-edge sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_gate_in       <= 4'd0;
      r_truth_table   <= 16'd0;
      r_exp_table     <= 16'd0;
      r_mismatch_cnt  <= 5'd0;
      r_first_bad_row <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state         <= RUN;
            r_gate_in       <= 4'd0;
            r_truth_table   <= 16'd0;
            r_exp_table     <= exp_table;
            r_mismatch_cnt  <= 5'd0;
            r_first_bad_row <= 4'd0;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            r_state   <= IDLE;
            r_gate_in <= 4'd0;
          end else if (w_sample) begin
            r_truth_table[w_bit_idx] <= gate_out;
            if (w_bit_bad) begin
              r_mismatch_cnt <= r_mismatch_cnt + 5'd1;
              if (r_mismatch_cnt == 5'd0) begin
                r_first_bad_row <= r_gate_in;
              end else begin
                r_first_bad_row <= r_first_bad_row;
              end
            end else begin
              r_mismatch_cnt <= r_mismatch_cnt;
            end
            if (r_gate_in == 4'd15) begin
              r_state <= DONE;
            end else begin
              r_gate_in <= r_gate_in + 4'd1;
            end
          end else begin
            r_state <= RUN;
          end
        end
        DONE: begin
          if (result_ready) begin
            r_state   <= IDLE;
            r_gate_in <= 4'd0;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_gate_in <= 4'd0;
        end
      endcase
    end
  end

  assign gate_in       = r_gate_in;
  assign busy          = w_run;
  assign result_valid  = (r_state == DONE);
  assign truth_table   = r_truth_table;
  assign match         = (r_state == DONE) && (r_truth_table == r_exp_table);
  assign mismatch_cnt  = r_mismatch_cnt;
  assign first_bad_row = r_first_bad_row;

endmodule

// File: tb/tb_gate_truth_table_reader.sv
// Self-checking bench: table-driven sweeps through a scoreboard queue plus
// hand-written abort, DONE-hold, SETTLE_CYCLES=1 and mid-sweep reset sequences.
module tb_gate_truth_table_reader;
  import gate_char_pkg::*;

  typedef struct {
    tt_t        gate_fn;
    tt_t        exp_tbl;
    tt_t        tt;
    logic       match;
    logic [4:0] cnt;
    logic [3:0] fbr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, abort = 1'b0, result_ready = 1'b0;
  tt_t         exp_table = 16'd0, gate_fn = 16'd0;
  logic [3:0]  gate_in, first_bad_row, model_idx;
  logic        gate_out, busy, result_valid, match;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_cnt;

  logic        start1 = 1'b0, ready1 = 1'b0;
  logic [3:0]  gate_in1, fbr1;
  logic        busy1, rv1, match1;
  logic [15:0] tt1;
  logic [4:0]  cnt1;

  // Gate netlist model: row r outputs bit 15-r of its name word.
  assign model_idx = 4'd15 - gate_in;
  assign gate_out  = gate_fn[model_idx];

  gate_truth_table_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_table(exp_table),
    .gate_in(gate_in), .gate_out(gate_out), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .truth_table(truth_table), .match(match),
    .mismatch_cnt(mismatch_cnt), .first_bad_row(first_bad_row)
  );

  gate_truth_table_reader #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .exp_table(16'hFFFF),
    .gate_in(gate_in1), .gate_out(1'b1), .busy(busy1), .result_valid(rv1),
    .result_ready(ready1), .truth_table(tt1), .match(match1),
    .mismatch_cnt(cnt1), .first_bad_row(fbr1)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[8];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic start_sweep(input tt_t fn, input tt_t ex);
    gate_fn   = fn;
    exp_table = ex;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!result_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic ack;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("ack_valid", {31'd0, result_valid}, 32'd0);
    chk("ack_gate_in", {28'd0, gate_in}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_gate_in"}, {28'd0, gate_in}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid"}, {31'd0, result_valid}, 32'd0);
    chk({tag, "_tt"}, {16'd0, truth_table}, 32'd0);
    chk({tag, "_match"}, {31'd0, match}, 32'd0);
    chk({tag, "_cnt"}, {27'd0, mismatch_cnt}, 32'd0);
    chk({tag, "_fbr"}, {28'd0, first_bad_row}, 32'd0);
  endtask

  task automatic compare_result(input vec_t e);
    chk("tt", {16'd0, truth_table}, {16'd0, e.tt});
    chk("match", {31'd0, match}, {31'd0, e.match});
    chk("mismatch_cnt", {27'd0, mismatch_cnt}, {27'd0, e.cnt});
    chk("first_bad_row", {28'd0, first_bad_row}, {28'd0, e.fbr});
  endtask

  initial begin
    int   cyc;
    logic seen;
    vec_t e;

    vecs[0] = '{16'hE605, 16'hE605, 16'hE605, 1'b1, 5'd0,  4'd0};
    vecs[1] = '{16'hE605, 16'hE604, 16'hE605, 1'b0, 5'd1,  4'd15};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b0, 5'd16, 4'd0};
    vecs[3] = '{16'h8001, 16'h0001, 16'h8001, 1'b0, 5'd1,  4'd0};
    vecs[4] = '{16'h1234, 16'h1634, 16'h1234, 1'b0, 5'd1,  4'd5};
    vecs[5] = '{16'hAAAA, 16'h5555, 16'hAAAA, 1'b0, 5'd16, 4'd0};
    vecs[6] = '{16'h00FF, 16'h00F0, 16'h00FF, 1'b0, 5'd4,  4'd12};
    vecs[7] = '{16'h6996, 16'h6996, 16'h6996, 1'b1, 5'd0,  4'd0};

    #12;
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven sweeps through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      start_sweep(vecs[i].gate_fn, vecs[i].exp_tbl);
      exp_q.push_back(vecs[i]);
      chk("busy_run", {31'd0, busy}, 32'd1);
      wait_done(cyc);
      chk("latency", cyc, 32'd32);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare_result(e);
      end
      ack();
    end

    // SETTLE_CYCLES=1: one row per cycle, constant-1 gate.
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("s1_gate_in", {28'd0, gate_in1}, k);
      @(posedge clk); #1;
    end
    chk("s1_valid", {31'd0, rv1}, 32'd1);
    chk("s1_tt", {16'd0, tt1}, 32'h0000FFFF);
    chk("s1_match", {31'd0, match1}, 32'd1);
    ready1 = 1'b1;
    @(posedge clk); #1;
    ready1 = 1'b0;
    chk("s1_ack", {31'd0, rv1}, 32'd0);

    // Abort at cycle 10 of a sweep.
    start_sweep(16'hE605, 16'hE605);
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_gate_in", {28'd0, gate_in}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen = seen | result_valid;
      @(posedge clk); #1;
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);
    start_sweep(16'hE605, 16'hE605);
    exp_q.push_back(vecs[0]);
    wait_done(cyc);
    chk("post_abort_latency", cyc, 32'd32);
    e = exp_q.pop_front();
    compare_result(e);
    ack();

    // DONE held with result_ready low; start pulses are ignored.
    start_sweep(16'hE605, 16'hE604);
    wait_done(cyc);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, result_valid}, 32'd1);
      chk("hold_busy", {31'd0, busy}, 32'd0);
      chk("hold_tt", {16'd0, truth_table}, 32'h0000E605);
      chk("hold_cnt", {27'd0, mismatch_cnt}, 32'd1);
    end
    start = 1'b0;
    ack();

    // Asynchronous reset mid-sweep at row 7.
    start_sweep(16'hE605, 16'hE605);
    cyc = 0;
    while (gate_in != 4'd7 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reach_row7", {28'd0, gate_in}, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      seen = seen | result_valid;
    end
    chk("rst_no_valid", {31'd0, seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
